exu_lsu_stage: RTL

- Multi-cycle execute/memory/writeback-select stage between decode and the register file write port.
- Replaces the single-cycle combinational EX/MEM path with handshake-driven operation:
  - valid/ready on the decode side;
  - a split request/response memory bus;
  - a registered writeback output.
- Supports variable-latency memory and back-pressure, and parametrises datapath width.

---
 rtl/exu_lsu_stage_pkg.sv | 55 +++++
 rtl/exu_lsu_stage_if.sv | 28 ++
 rtl/exu_lsu_stage_align.sv | 37 +++
 rtl/exu_lsu_stage.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/exu_lsu_stage_pkg.sv
// Shared types for the execute/LSU stage: ALU opcodes, memory access encodings,
// writeback select, FSM states and the access-size byte mask.
package exu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    MEM_NONE    = 2'b00,
    MEM_STORE   = 2'b01,
    MEM_LOAD    = 2'b10,
    MEM_ILLEGAL = 2'b11
  } mem_rw_e;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2,
    SIZE_D = 2'd3
  } mem_size_e;

  typedef enum logic [1:0] {
    WB_MEM = 2'd0,
    WB_ALU = 2'd1,
    WB_PC4 = 2'd2,
    WB_CSR = 2'd3
  } wb_sel_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } lsu_state_e;

  function automatic logic [7:0] sizeMask(input mem_size_e size);
    sizeMask = 8'hFF;
    case (size)
      SIZE_B:  sizeMask = 8'h01;
      SIZE_H:  sizeMask = 8'h03;
      SIZE_W:  sizeMask = 8'h0F;
      default: sizeMask = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/exu_lsu_stage_if.sv
// Split request/response memory bus between the LSU stage (master) and memory (slave).
interface exu_lsu_stage_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  localparam int STRB_W = XLEN / 8;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_req_we;
  logic [XLEN-1:0]   mem_req_wdata;
  logic [STRB_W-1:0] mem_req_wstrb;
  logic              mem_rsp_valid;
  logic              mem_rsp_ready;
  logic [XLEN-1:0]   mem_rsp_rdata;
  logic              mem_rsp_err;

  modport master (
    output mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata, mem_req_wstrb, mem_rsp_ready,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_err
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata, mem_req_wstrb, mem_rsp_ready,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_err
  );
endinterface

// File: rtl/exu_lsu_stage_align.sv
// Byte-lane steering: store data/strobe placement and load extract with sign/zero extension.
module exu_lsu_align
  import exu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [$clog2(XLEN/8)-1:0] off,
  input  mem_size_e                 size,
  input  logic                      isUnsigned,
  input  logic [XLEN-1:0]           storeData,
  input  logic [XLEN-1:0]           rdata,
  output logic [XLEN-1:0]           wdata,
  output logic [XLEN/8-1:0]         wstrb,
  output logic [XLEN-1:0]           loadData
);
  localparam int STRB_W = XLEN / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  logic [OFF_W+2:0] bitOff;
  logic [XLEN-1:0]  shifted;

  assign bitOff  = {off, 3'b000};
  assign wstrb   = STRB_W'(sizeMask(size)) << off;
  assign wdata   = storeData << bitOff;
  assign shifted = rdata >> bitOff;

  always_comb begin
    loadData = shifted;
    case (size)
      SIZE_B:  loadData = isUnsigned ? XLEN'(shifted[7:0])  : XLEN'($signed(shifted[7:0]));
      SIZE_H:  loadData = isUnsigned ? XLEN'(shifted[15:0]) : XLEN'($signed(shifted[15:0]));
      SIZE_W:  loadData = isUnsigned ? XLEN'(shifted[31:0]) : XLEN'($signed(shifted[31:0]));
      default: loadData = shifted;
    endcase
  end

endmodule

// File: rtl/exu_lsu_stage.sv
// Handshaked execute/memory/writeback-select stage with registered writeback output.
// EXU_MISALIGN_CHK_EN: misaligned half/word/dword accesses retire with out_err instead of issuing.
module exu_lsu_stage
  import exu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32,
  parameter int STRB_W = XLEN / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [XLEN-1:0]   in_op_a,
  input  logic [XLEN-1:0]   in_op_b,
  input  logic [XLEN-1:0]   in_store_data,
  input  logic [XLEN-1:0]   in_csr_data,
  input  logic [3:0]        in_alu_op,
  input  logic [1:0]        in_mem_rw,
  input  logic [1:0]        in_mem_size,
  input  logic              in_mem_unsigned,
  input  logic [1:0]        in_wb_sel,
  input  logic [4:0]        in_rd,
  input  logic              in_reg_write,
  exu_lsu_stage_if.master   mem,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        out_rd,
  output logic              out_reg_write,
  output logic [XLEN-1:0]   out_wb_data,
  output logic [ADDR_W-1:0] out_pc,
  output logic [XLEN-1:0]   out_alu,
  output logic              out_err
);
  localparam int SH_W  = $clog2(XLEN);
  localparam int OFF_W = $clog2(STRB_W);

  lsu_state_e state, nextState;

  logic [XLEN-1:0]   aluRes;
  logic [SH_W-1:0]   shamt;
  logic              accept, isMemIn, misErr, aluRetire, memRetire;
  mem_rw_e           rwIn;
  mem_size_e         sizeIn;
  logic [2:0]        lowMask;
  logic [ADDR_W-1:0] accAddr, issueAddr;

  logic [ADDR_W-1:0] rAddr, rPc;
  logic              rWe, rUnsigned, rRegWrite;
  logic [XLEN-1:0]   rStoreData, rCsr, rAlu;
  mem_size_e         rSize;
  wb_sel_e           rWbSel;
  logic [4:0]        rRd;

  logic [STRB_W-1:0] laneStrb;
  logic [XLEN-1:0]   loadData;

  function automatic logic [XLEN-1:0] wbMux(input wb_sel_e sel, input logic [XLEN-1:0] memData,
                                            input logic [XLEN-1:0] aluVal, input logic [ADDR_W-1:0] pc,
                                            input logic [XLEN-1:0] csr);
    wbMux = csr;
    case (sel)
      WB_MEM:  wbMux = memData;
      WB_ALU:  wbMux = aluVal;
      WB_PC4:  wbMux = XLEN'(pc + ADDR_W'(4));
      default: wbMux = csr;
    endcase
  endfunction

  assign shamt = in_op_b[SH_W-1:0];

  always_comb begin
    aluRes = '0;
    case (alu_op_e'(in_alu_op))
      ALU_ADD:  aluRes = in_op_a + in_op_b;
      ALU_SUB:  aluRes = in_op_a - in_op_b;
      ALU_SLL:  aluRes = in_op_a << shamt;
      ALU_SLT:  aluRes = XLEN'($signed(in_op_a) < $signed(in_op_b));
      ALU_SLTU: aluRes = XLEN'(in_op_a < in_op_b);
      ALU_XOR:  aluRes = in_op_a ^ in_op_b;
      ALU_SRL:  aluRes = in_op_a >> shamt;
      ALU_SRA:  aluRes = $signed(in_op_a) >>> shamt;
      ALU_OR:   aluRes = in_op_a | in_op_b;
      ALU_AND:  aluRes = in_op_a & in_op_b;
      default:  aluRes = '0;
    endcase
  end

  assign rwIn    = mem_rw_e'(in_mem_rw);
  assign sizeIn  = mem_size_e'(in_mem_size);
  assign isMemIn = (rwIn == MEM_LOAD) || (rwIn == MEM_STORE);
  assign accAddr = aluRes[ADDR_W-1:0];

  always_comb begin
    lowMask = 3'b000;
    case (sizeIn)
      SIZE_H:  lowMask = 3'b001;
      SIZE_W:  lowMask = 3'b011;
      SIZE_D:  lowMask = 3'b111;
      default: lowMask = 3'b000;
    endcase
  end

`ifdef EXU_MISALIGN_CHK_EN
  assign misErr    = isMemIn && (|(accAddr[2:0] & lowMask));
  assign issueAddr = accAddr;
`else
  assign misErr    = 1'b0;
  assign issueAddr = {accAddr[ADDR_W-1:3], accAddr[2:0] & ~lowMask};
`endif

  assign in_ready  = (state == IDLE) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  // Non-memory ops and rejected misaligned accesses retire straight from IDLE.
  assign aluRetire = accept && (!isMemIn || misErr);
  assign memRetire = (state == RSP) && mem.mem_rsp_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (accept && isMemIn && !misErr) nextState = REQ;
      REQ:     if (mem.mem_req_ready) nextState = RSP;
      RSP:     if (mem.mem_rsp_valid) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rAddr      <= '0;
      rPc        <= '0;
      rWe        <= 1'b0;
      rUnsigned  <= 1'b0;
      rRegWrite  <= 1'b0;
      rStoreData <= '0;
      rCsr       <= '0;
      rAlu       <= '0;
      rSize      <= SIZE_B;
      rWbSel     <= WB_MEM;
      rRd        <= '0;
    end else if (accept) begin
      rAddr      <= issueAddr;
      rPc        <= in_pc;
      rWe        <= (rwIn == MEM_STORE);
      rUnsigned  <= in_mem_unsigned;
      rRegWrite  <= in_reg_write;
      rStoreData <= in_store_data;
      rCsr       <= in_csr_data;
      rAlu       <= aluRes;
      rSize      <= sizeIn;
      rWbSel     <= wb_sel_e'(in_wb_sel);
      rRd        <= in_rd;
    end
  end

  exu_lsu_align #(.XLEN(XLEN)) u_align (
    .off       (rAddr[OFF_W-1:0]),
    .size      (rSize),
    .isUnsigned(rUnsigned),
    .storeData (rStoreData),
    .rdata     (mem.mem_rsp_rdata),
    .wdata     (mem.mem_req_wdata),
    .wstrb     (laneStrb),
    .loadData  (loadData)
  );

  assign mem.mem_req_valid = (state == REQ);
  assign mem.mem_rsp_ready = (state == RSP);
  assign mem.mem_req_addr  = rAddr;
  assign mem.mem_req_we    = rWe;
  assign mem.mem_req_wstrb = rWe ? laneStrb : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid     <= 1'b0;
      out_rd        <= '0;
      out_reg_write <= 1'b0;
      out_wb_data   <= '0;
      out_pc        <= '0;
      out_alu       <= '0;
      out_err       <= 1'b0;
    end else if (aluRetire) begin
      out_valid     <= 1'b1;
      out_rd        <= in_rd;
      out_reg_write <= in_reg_write && !misErr;
      out_wb_data   <= misErr ? '0 : wbMux(wb_sel_e'(in_wb_sel), '0, aluRes, in_pc, in_csr_data);
      out_pc        <= in_pc;
      out_alu       <= aluRes;
      out_err       <= misErr;
    end else if (memRetire) begin
      out_valid     <= 1'b1;
      out_rd        <= rRd;
      out_reg_write <= rRegWrite && !mem.mem_rsp_err;
      out_wb_data   <= mem.mem_rsp_err ? '0 : wbMux(rWbSel, loadData, rAlu, rPc, rCsr);
      out_pc        <= rPc;
      out_alu       <= rAlu;
      out_err       <= mem.mem_rsp_err;
    end else if (out_ready) begin
      out_valid     <= 1'b0;
    end
  end

endmodule
